// File: rtl/mem_bridge.sv
// mem_bridge: turns the control unit's level-held memory request into a req/ack bus transaction with timeout.
// Optional MEM_BRIDGE_ALIGN_CHK_EN rejects word-misaligned addresses without touching the bus.
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_rdy,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // state | meaning
  // IDLE  | waiting for mem_req; bus_ack ignored
  // REQ   | bus_req held, waiting for bus_ack or timeout expiry
  // DONE  | one-cycle mem_rdy pulse; mem_req ignored
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bit              TO_EN     = (TIMEOUT_CYC != 0);
  localparam int unsigned     TO_LOAD_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TO_LOAD_I);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            breq_q, breq_d;
  logic            bwe_q, bwe_d;
  logic [31:0]     baddr_q, baddr_d;
  logic [31:0]     bwdata_q, bwdata_d;
  logic            misaligned;

`ifdef MEM_BRIDGE_ALIGN_CHK_EN
  assign misaligned = |mem_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      breq_q   <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      breq_q   <= breq_d;
      bwe_q    <= bwe_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
    end
  end

  // Timeout timer counts down from TIMEOUT_CYC-1; expiry is the REQ cycle where it reads zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_d    = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    breq_d   = breq_q;
    bwe_d    = bwe_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          err_d = 1'b0;
          if (misaligned) begin
            rdata_d = '0;
            err_d   = 1'b1;
            rdy_d   = 1'b1;
            state_d = DONE;
          end else begin
            breq_d   = 1'b1;
            bwe_d    = mem_we;
            baddr_d  = mem_addr;
            bwdata_d = mem_wdata;
            cnt_d    = TO_LOAD;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          breq_d  = 1'b0;
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = DONE;
          if (!bwe_q) begin
            rdata_d = bus_rdata;
          end
        end else if (TO_EN && (cnt_q == '0)) begin
          breq_d  = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          rdy_d   = 1'b1;
          state_d = DONE;
        end else if (TO_EN) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign mem_rdy   = rdy_q;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;
  assign busy      = busy_q;
  assign bus_req   = breq_q;
  assign bus_we    = bwe_q;
  assign bus_addr  = baddr_q;
  assign bus_wdata = bwdata_q;

endmodule
